// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures decoded ID state for EX, inserts bubbles on flush and on
// load-use hazards (which it detects itself), holds on stall, and keeps a
// saturating count of inserted bubbles.
//
// Control semantics: stall_i holds every EX register; flush_i squashes the
// EX slot and wins over stall_i; hazard_o tells IF/PC and IF/ID to hold
// while a bubble is loaded here, so the dependent instruction is retried.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [2:0]       id_alu_op_i,
    input  logic [2:0]       id_func3_i,
    input  logic             id_func7_i,
    input  logic             id_alu_src_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             id_mem_to_reg_i,
    input  logic             id_branch_i,
    input  logic             id_jump_i,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       ex_rd_addr_o,
    output logic             ex_uses_rs1_o,
    output logic             ex_uses_rs2_o,
    output logic [2:0]       ex_alu_op_o,
    output logic [2:0]       ex_func3_o,
    output logic             ex_func7_o,
    output logic             ex_alu_src_o,
    output logic             ex_reg_write_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic             ex_mem_to_reg_o,
    output logic             ex_branch_o,
    output logic             ex_jump_o,
    output logic             hazard_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    // All EX-stage state in one record; an all-zero record is a bubble
    // (ALUOp/func3/func7 = 0 decodes as add, every side-effect bit is 0).
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            uses_rs1;
        logic            uses_rs2;
        logic [2:0]      alu_op;
        logic [2:0]      func3;
        logic            func7;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
    } ex_t;

    ex_t              id_d;
    ex_t              ex_q;
    ex_t              ex_d;
    logic             insert_bubble;
    logic [CNT_W-1:0] cnt_q;

    assign id_d = '{
        valid:      id_valid_i,
        pc:         id_pc_i,
        rs1_data:   id_rs1_data_i,
        rs2_data:   id_rs2_data_i,
        imm:        id_imm_i,
        rs1_addr:   id_rs1_addr_i,
        rs2_addr:   id_rs2_addr_i,
        rd_addr:    id_rd_addr_i,
        uses_rs1:   id_uses_rs1_i,
        uses_rs2:   id_uses_rs2_i,
        alu_op:     id_alu_op_i,
        func3:      id_func3_i,
        func7:      id_func7_i,
        alu_src:    id_alu_src_i,
        reg_write:  id_reg_write_i,
        mem_read:   id_mem_read_i,
        mem_write:  id_mem_write_i,
        mem_to_reg: id_mem_to_reg_i,
        branch:     id_branch_i,
        jump:       id_jump_i
    };

    // Load-use: a load in EX whose non-x0 destination is read by the valid ID instruction.
    always_comb begin
        hazard_o = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) && id_valid_i &&
                   ((id_uses_rs1_i && (id_rs1_addr_i == ex_q.rd_addr)) ||
                    (id_uses_rs2_i && (id_rs2_addr_i == ex_q.rd_addr)));
    end

    // Next EX contents by priority: flush, stall, hazard, normal capture.
    always_comb begin
        ex_d          = ex_q;
        insert_bubble = 1'b0;
        if (flush_i) begin
            ex_d          = '0;
            insert_bubble = 1'b1;
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (hazard_o) begin
            ex_d          = '0;
            insert_bubble = 1'b1;
        end else if (id_valid_i) begin
            ex_d = id_d;
        end else begin
            // An empty ID slot becomes a bubble but is not counted.
            ex_d = '0;
        end
    end

    // EX-stage register and saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q <= ex_d;
            if (insert_bubble && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_pc_o         = ex_q.pc;
    assign ex_rs1_data_o   = ex_q.rs1_data;
    assign ex_rs2_data_o   = ex_q.rs2_data;
    assign ex_imm_o        = ex_q.imm;
    assign ex_rs1_addr_o   = ex_q.rs1_addr;
    assign ex_rs2_addr_o   = ex_q.rs2_addr;
    assign ex_rd_addr_o    = ex_q.rd_addr;
    assign ex_uses_rs1_o   = ex_q.uses_rs1;
    assign ex_uses_rs2_o   = ex_q.uses_rs2;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_func3_o      = ex_q.func3;
    assign ex_func7_o      = ex_q.func7;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign ex_mem_read_o   = ex_q.mem_read;
    assign ex_mem_write_o  = ex_q.mem_write;
    assign ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign ex_branch_o     = ex_q.branch;
    assign ex_jump_o       = ex_q.jump;
    assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed scenarios plus randomized traffic
// against a transaction-level model of the EX slot and the bubble count.
// Two instances share stimulus: default counter width and a 4-bit counter.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        uses_rs1;
        logic        uses_rs2;
        logic [2:0]  alu_op;
        logic [2:0]  func3;
        logic        func7;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
    } st_t;

    localparam int W = $bits(st_t);

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    st_t         id_s;
    st_t         obs;
    st_t         obs_sat;
    logic        hz;
    logic        hz_sat;
    logic [15:0] cnt;
    logic [3:0]  cnt_sat;

    // reference model state
    st_t         m;
    int unsigned mcnt;
    logic [W-1:0] exp_q[$];

    int n_checks;
    int n_errors;

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .id_valid_i(id_s.valid), .id_pc_i(id_s.pc),
        .id_rs1_data_i(id_s.rs1_data), .id_rs2_data_i(id_s.rs2_data), .id_imm_i(id_s.imm),
        .id_rs1_addr_i(id_s.rs1_addr), .id_rs2_addr_i(id_s.rs2_addr), .id_rd_addr_i(id_s.rd_addr),
        .id_uses_rs1_i(id_s.uses_rs1), .id_uses_rs2_i(id_s.uses_rs2),
        .id_alu_op_i(id_s.alu_op), .id_func3_i(id_s.func3), .id_func7_i(id_s.func7),
        .id_alu_src_i(id_s.alu_src), .id_reg_write_i(id_s.reg_write),
        .id_mem_read_i(id_s.mem_read), .id_mem_write_i(id_s.mem_write),
        .id_mem_to_reg_i(id_s.mem_to_reg), .id_branch_i(id_s.branch), .id_jump_i(id_s.jump),
        .ex_valid_o(obs.valid), .ex_pc_o(obs.pc),
        .ex_rs1_data_o(obs.rs1_data), .ex_rs2_data_o(obs.rs2_data), .ex_imm_o(obs.imm),
        .ex_rs1_addr_o(obs.rs1_addr), .ex_rs2_addr_o(obs.rs2_addr), .ex_rd_addr_o(obs.rd_addr),
        .ex_uses_rs1_o(obs.uses_rs1), .ex_uses_rs2_o(obs.uses_rs2),
        .ex_alu_op_o(obs.alu_op), .ex_func3_o(obs.func3), .ex_func7_o(obs.func7),
        .ex_alu_src_o(obs.alu_src), .ex_reg_write_o(obs.reg_write),
        .ex_mem_read_o(obs.mem_read), .ex_mem_write_o(obs.mem_write),
        .ex_mem_to_reg_o(obs.mem_to_reg), .ex_branch_o(obs.branch), .ex_jump_o(obs.jump),
        .hazard_o(hz), .bubble_cnt_o(cnt)
    );

    id_ex_stage_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .id_valid_i(id_s.valid), .id_pc_i(id_s.pc),
        .id_rs1_data_i(id_s.rs1_data), .id_rs2_data_i(id_s.rs2_data), .id_imm_i(id_s.imm),
        .id_rs1_addr_i(id_s.rs1_addr), .id_rs2_addr_i(id_s.rs2_addr), .id_rd_addr_i(id_s.rd_addr),
        .id_uses_rs1_i(id_s.uses_rs1), .id_uses_rs2_i(id_s.uses_rs2),
        .id_alu_op_i(id_s.alu_op), .id_func3_i(id_s.func3), .id_func7_i(id_s.func7),
        .id_alu_src_i(id_s.alu_src), .id_reg_write_i(id_s.reg_write),
        .id_mem_read_i(id_s.mem_read), .id_mem_write_i(id_s.mem_write),
        .id_mem_to_reg_i(id_s.mem_to_reg), .id_branch_i(id_s.branch), .id_jump_i(id_s.jump),
        .ex_valid_o(obs_sat.valid), .ex_pc_o(obs_sat.pc),
        .ex_rs1_data_o(obs_sat.rs1_data), .ex_rs2_data_o(obs_sat.rs2_data), .ex_imm_o(obs_sat.imm),
        .ex_rs1_addr_o(obs_sat.rs1_addr), .ex_rs2_addr_o(obs_sat.rs2_addr), .ex_rd_addr_o(obs_sat.rd_addr),
        .ex_uses_rs1_o(obs_sat.uses_rs1), .ex_uses_rs2_o(obs_sat.uses_rs2),
        .ex_alu_op_o(obs_sat.alu_op), .ex_func3_o(obs_sat.func3), .ex_func7_o(obs_sat.func7),
        .ex_alu_src_o(obs_sat.alu_src), .ex_reg_write_o(obs_sat.reg_write),
        .ex_mem_read_o(obs_sat.mem_read), .ex_mem_write_o(obs_sat.mem_write),
        .ex_mem_to_reg_o(obs_sat.mem_to_reg), .ex_branch_o(obs_sat.branch), .ex_jump_o(obs_sat.jump),
        .hazard_o(hz_sat), .bubble_cnt_o(cnt_sat)
    );

    // single checking task
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // load-use rule evaluated on the modelled EX slot and the current ID slot
    function automatic logic model_haz(input st_t e, input st_t d);
        logic dep;
        dep = (d.uses_rs1 && d.rs1_addr == e.rd_addr) || (d.uses_rs2 && d.rs2_addr == e.rd_addr);
        return e.valid && e.mem_read && (e.rd_addr != 5'd0) && d.valid && dep;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // driver: random ID instruction with a small register window to provoke hazards
    task automatic drive_rand_id();
        id_s.valid      = ($urandom_range(0, 4) != 0);
        id_s.pc         = $urandom;
        id_s.rs1_data   = $urandom;
        id_s.rs2_data   = $urandom;
        id_s.imm        = $urandom;
        id_s.rs1_addr   = 5'($urandom_range(0, 3));
        id_s.rs2_addr   = 5'($urandom_range(0, 3));
        id_s.rd_addr    = 5'($urandom_range(0, 3));
        id_s.uses_rs1   = 1'($urandom_range(0, 1));
        id_s.uses_rs2   = 1'($urandom_range(0, 1));
        id_s.alu_op     = 3'($urandom_range(0, 7));
        id_s.func3      = 3'($urandom_range(0, 7));
        id_s.func7      = 1'($urandom_range(0, 1));
        id_s.alu_src    = 1'($urandom_range(0, 1));
        id_s.reg_write  = 1'($urandom_range(0, 1));
        id_s.mem_read   = 1'($urandom_range(0, 1));
        id_s.mem_write  = 1'($urandom_range(0, 1));
        id_s.mem_to_reg = 1'($urandom_range(0, 1));
        id_s.branch     = 1'($urandom_range(0, 1));
        id_s.jump       = 1'($urandom_range(0, 1));
    endtask

    // one clock: check hazard before the edge, predict, check EX state after it
    task automatic cycle();
        logic  h;
        st_t   e;
        #1;
        h = model_haz(m, id_s);
        chk("hazard", W'(hz), W'(h));
        chk("hazard_sat", W'(hz_sat), W'(h));
        @(posedge clk);
        if (flush) begin
            m = '0;
            mcnt++;
        end else if (stall) begin
            m = m;
        end else if (h) begin
            m = '0;
            mcnt++;
        end else begin
            m = id_s.valid ? id_s : '0;
        end
        exp_q.push_back(m);
        #1;
        e = exp_q.pop_front();
        chk("ex_state", obs, e);
        chk("ex_state_sat", obs_sat, e);
        chk("bubble_cnt", W'(cnt), W'(sat(mcnt, 65535)));
        chk("bubble_cnt_sat", W'(cnt_sat), W'(sat(mcnt, 15)));
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        id_s  = '0;
        m     = '0;
        mcnt  = 0;
        repeat (2) @(negedge clk);
        chk("reset_ex", obs, '0);
        chk("reset_cnt", W'(cnt), '0);
        rst_n = 1'b1;

        // pass-through
        id_s          = '0;
        id_s.valid    = 1'b1;
        id_s.alu_op   = 3'b001;
        id_s.func3    = 3'b111;
        id_s.imm      = 32'h0000_00FF;
        id_s.rd_addr  = 5'd5;
        cycle();
        chk("pt_alu_op", W'(obs.alu_op), W'(3'b001));
        chk("pt_func3", W'(obs.func3), W'(3'b111));
        chk("pt_imm", W'(obs.imm), W'(32'hFF));
        chk("pt_rd", W'(obs.rd_addr), W'(5'd5));
        chk("pt_valid", W'(obs.valid), W'(1'b1));

        // load-use: lw x3 then add x4,x3,x1
        id_s = '0; id_s.valid = 1'b1; id_s.alu_op = 3'b010; id_s.mem_read = 1'b1;
        id_s.mem_to_reg = 1'b1; id_s.reg_write = 1'b1; id_s.rd_addr = 5'd3;
        id_s.rs1_addr = 5'd2; id_s.uses_rs1 = 1'b1;
        cycle();
        id_s = '0; id_s.valid = 1'b1; id_s.reg_write = 1'b1; id_s.rd_addr = 5'd4;
        id_s.rs1_addr = 5'd3; id_s.rs2_addr = 5'd1; id_s.uses_rs1 = 1'b1; id_s.uses_rs2 = 1'b1;
        #1;
        chk("lu_hazard", W'(hz), W'(1'b1));
        cycle();
        chk("lu_bubble_valid", W'(obs.valid), W'(1'b0));
        chk("lu_cnt", W'(cnt), W'(16'd1));
        #1;
        chk("lu_hazard_clear", W'(hz), W'(1'b0));
        cycle();
        chk("lu_dep_enters", W'(obs.rd_addr), W'(5'd4));

        // load to x0 never raises a hazard
        id_s = '0; id_s.valid = 1'b1; id_s.alu_op = 3'b010; id_s.mem_read = 1'b1;
        id_s.rd_addr = 5'd0;
        cycle();
        id_s = '0; id_s.valid = 1'b1; id_s.rd_addr = 5'd4; id_s.rs1_addr = 5'd0;
        id_s.uses_rs1 = 1'b1;
        #1;
        chk("x0_no_hazard", W'(hz), W'(1'b0));
        cycle();

        // stall hold for 3 cycles with changing ID inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand_id();
            cycle();
        end
        chk("stall_held_rd", W'(obs.rd_addr), W'(5'd4));
        stall = 1'b0;

        // flush over stall
        flush = 1'b1;
        stall = 1'b1;
        drive_rand_id();
        cycle();
        chk("flush_stall_valid", W'(obs.valid), W'(1'b0));
        flush = 1'b0;
        stall = 1'b0;

        // 20 consecutive flushes saturate the 4-bit counter
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand_id();
            cycle();
        end
        chk("sat_cnt", W'(cnt_sat), W'(4'hF));
        flush = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand_id();
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 6) == 0);
            cycle();
        end

        // asynchronous reset while EX holds a valid instruction, mid-stall
        flush = 1'b0;
        stall = 1'b0;
        id_s = '0; id_s.valid = 1'b1; id_s.pc = 32'h0000_1000; id_s.rd_addr = 5'd7;
        cycle();
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ex", obs, '0);
        chk("async_rst_cnt", W'(cnt), '0);
        chk("async_rst_cnt_sat", W'(cnt_sat), '0);
        m    = '0;
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive_rand_id();
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 6) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
